// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared defaults, state encoding and helper functions for
//                the N-channel round-robin arbiter. Helpers work on a fixed
//                ARB_MAX_N-wide vector; callers cast to their own width.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int ARB_N_DEFAULT        = 4;
    localparam int ARB_MAX_HOLD_DEFAULT = 16;

    // Upper bound on channel count supported by the helper functions.
    localparam int ARB_MAX_N   = 32;
    localparam int ARB_IDX_W   = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Binary index of the set bit in a one-hot (or zero) vector.
    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Mask with every bit at or above the pointer set: the channels that
    // come before the wrap point in the rotating search order.
    function automatic logic [ARB_MAX_N-1:0] prio_mask(input logic [ARB_IDX_W-1:0] ptr);
        return {ARB_MAX_N{1'b1}} << ptr;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/round_robin_arbiter_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_arbiter_n_if
//  Description : Request/grant bundle between requesters (master) and the
//                round-robin arbiter (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface round_robin_arbiter_n_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             hold_expired;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx,
        input  hold_expired
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_idx,
        output hold_expired
    );
endinterface : round_robin_arbiter_n_if
`default_nettype wire

// File: rtl/rr_pick_n.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick_n
//  Description : Combinational rotating-priority picker. Returns the first
//                set request in the order ptr, ptr+1, ..., N-1, 0, ..., ptr-1
//                as a one-hot vector (zero when no request is set).
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick_n
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N-1:0]     o_win
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_dbl_win;

    // Lower half holds requests at or above ptr, upper half holds all
    // requests (the wrapped tail). The lowest set bit of the doubled vector
    // is therefore the first requester in rotating order; folding both
    // halves together gives the winner.
    always_comb begin
        w_mask    = N'(prio_mask(ARB_IDX_W'(i_ptr)));
        w_dbl     = {i_req, i_req & w_mask};
        w_dbl_win = w_dbl & ~(w_dbl - (2*N)'(1));
        o_win     = w_dbl_win[N-1:0] | w_dbl_win[2*N-1:N];
    end

endmodule : rr_pick_n
`default_nettype wire

// File: rtl/round_robin_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_arbiter_n
//  Description : N-channel round-robin arbiter with registered one-hot grant,
//                grant lock while the owner keeps requesting, and forced
//                rotation after MAX_HOLD cycles when others are waiting.
//                N must not exceed arb_pkg::ARB_MAX_N.
//  Revision    : 1.0  initial release
// ============================================================================
module round_robin_arbiter_n
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEFAULT,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    round_robin_arbiter_n_if.slave bus
);

    arb_state_t       r_state;
    logic [N-1:0]     r_grant;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_expired;

    arb_state_t       w_state_nxt;
    logic [N-1:0]     w_grant_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_expired_nxt;

    logic [N-1:0]     w_arb_req;
    logic [N-1:0]     w_win;
    logic             w_win_any;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_win_ptr;
    logic             w_owner_req;
    logic             w_at_cap;

    // The current owner is excluded from the arbitration that decides its
    // successor, so a release or a forced rotation never re-picks it.
    always_comb begin
        w_arb_req   = (r_state == ST_OWNED) ? (bus.req & ~r_grant) : bus.req;
        w_owner_req = |(bus.req & r_grant);
        w_at_cap    = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD));
    end

    rr_pick_n #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (w_arb_req),
        .i_ptr (r_ptr),
        .o_win (w_win)
    );

    // Winner index and the pointer value that makes the winner lowest
    // priority on the next arbitration.
    always_comb begin
        w_win_any = |w_win;
        w_win_idx = IDX_W'(onehot_to_idx(ARB_MAX_N'(w_win)));
        w_win_ptr = (w_win_idx == IDX_W'(N - 1)) ? '0 : (w_win_idx + IDX_W'(1));
    end

    // Next-state and next-output decision for the IDLE/OWNED machine.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_expired_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_any) begin
                    w_state_nxt = ST_OWNED;
                    w_grant_nxt = w_win;
                    w_idx_nxt   = w_win_idx;
                    w_ptr_nxt   = w_win_ptr;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_OWNED: begin
                if (w_owner_req && !w_at_cap) begin
                    // Owner keeps the resource; with unlimited hold the
                    // counter carries no meaning and is left alone.
                    if (MAX_HOLD != 0) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (w_owner_req) begin
                    if (w_win_any) begin
                        w_grant_nxt   = w_win;
                        w_idx_nxt     = w_win_idx;
                        w_ptr_nxt     = w_win_ptr;
                        w_cnt_nxt     = CNT_W'(1);
                        w_expired_nxt = 1'b1;
                    end else begin
                        // Nobody is waiting: restart the hold window.
                        w_cnt_nxt = CNT_W'(1);
                    end
                end else begin
                    if (w_win_any) begin
                        w_grant_nxt = w_win;
                        w_idx_nxt   = w_win_idx;
                        w_ptr_nxt   = w_win_ptr;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset drops the grant
    // immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_valid   <= |w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    assign bus.grant        = r_grant;
    assign bus.grant_valid  = r_valid;
    assign bus.grant_idx    = r_idx;
    assign bus.hold_expired = r_expired;

endmodule : round_robin_arbiter_n
`default_nettype wire
